vdiv16_seq: RTL
===============

Name: vdiv16_seq

Overview:
- Sequential vector-by-scalar divider. It is the inverse operation of the 16-lane half-precision scalar multiplier.
- Divides each of NLANES IEEE-754 binary16 lanes of `vecin` by one binary16 `scalar`: quotient lane i = vecin lane i / scalar.
- One shared restoring mantissa divider is time-multiplexed across the lanes, trading latency for area.
- Used by the vector unit for normalisation and scaling ops; it produces the same lane packing the multiplier consumes (lane 0 = bits [15:0]).

Parameters:
- NLANES, 16, number of 16-bit lanes processed; legal range 1..16; vector widths are 16*NLANES.
- QBITS, 12, quotient bits generated per lane; fixed at 12 for binary16 and not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- scalar  input  16  binary16 divisor
- vecin  input  16*NLANES  binary16 dividend lanes
- quotient  output  16*NLANES  binary16 result lanes
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result and flags valid
- Ovrflw  output  1  sticky: some lane overflowed to infinity
- Undrflw  output  1  sticky: some lane flushed to zero
- DivZero  output  1  sticky: finite nonzero dividend divided by zero
- Invalid  output  1  sticky: some lane produced NaN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - quotient=0, busy=0, done=0, all flags=0.
- Reset mid-operation: aborts immediately; partial results are discarded and all outputs return to their reset values.
- Start acceptance:
  - In IDLE, start=1 at a rising edge latches scalar and vecin.
  - The same edge clears quotient and all flags, then enters LANE_PREP with lane index 0.
  - start while busy is ignored.
  - Input changes after acceptance have no effect.
- States and transitions:
  - IDLE -> LANE_PREP on start.
  - LANE_PREP (1 cycle): unpack sign, exponent and mantissa; set the remainder and classify special cases.
  - DIV (12 cycles): one restoring quotient bit per cycle, MSB first.
  - PACK (1 cycle): write the lane into quotient and OR in the flags.
  - After PACK, go to LANE_PREP for the next lane, or to DONE after lane NLANES-1.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Latency:
  - 14 cycles per lane; every lane takes the full 14 cycles, special cases included.
  - For NLANES=16, done is high in the 226th cycle after the accepting edge.
  - Back-to-back operation: start may be accepted in the cycle after DONE.
- Arithmetic, per lane (sA, eA, fA dividend; sB, eB, fB divisor):
  - Sign = sA^sB.
  - Any exponent 0 is treated as zero: subnormals flush to zero on input.
  - mA = {1,fA}, mB = {1,fB}.
  - q = floor(mA*2^11 / mB), 12 bits.
  - If q[11]=1: frac=q[10:1], E=eA-eB+15.
  - Else: frac=q[9:0], E=eA-eB+14.
  - Rounding is truncation (round toward zero).
  - E>=31: result {sign,0x7C00}, Ovrflw=1.
  - E<=0: result {sign,0x0000}, Undrflw=1.
- Special cases (checked in this priority order):
  1. Any operand with exponent 31, or 0/0: result 0x7E00, Invalid=1.
  2. Nonzero finite / 0: result {sign,0x7C00}, DivZero=1; Ovrflw is not set.
  3. 0 / nonzero finite: result {sign,0x0000}; no flag.
- Output stability:
  - quotient lanes update only in their PACK cycle.
  - quotient and flags hold their values after done until the next accepted start.

Test Plan:
- scalar=0x3C00, vecin all lanes 0x3C00, start pulse -> done at cycle 226; quotient = 0x3C00 repeating; all flags 0; busy high cycles 1..225.
- scalar=0x4200 (3.0), all lanes 0x3C00 -> all lanes 0x3555 (1/3 truncated); scalar=0x4000 with lanes 0x4200 -> all lanes 0x3E00.
- scalar=0xBC00, lanes alternating 0x4000/0x0000 -> lanes 0xC000 / 0x8000; flags 0.
- scalar=0x0000, lane0=0x3C00, lane1=0x0000, lane2=0x7C00, others 0x4000 -> lane0 0x7C00, lane1 0x7E00, lane2 0x7E00, others 0x7C00; DivZero=1, Invalid=1, Ovrflw=0.
- scalar=0x0400, lanes 0x7BFF -> all 0x7C00, Ovrflw=1; then scalar=0x7800, lanes 0x0400 -> all 0x0000, Undrflw=1, Ovrflw cleared by the new start.
- Assert rst_n=0 at cycle 100 of an operation -> all outputs 0 asynchronously; start re-accepted after release; start pulsed while busy is ignored and done occurs exactly once.

Source files
------------

// File: rtl/vdiv16_seq_if.sv
// Operand/result bundle for the sequential binary16 vector-by-scalar divider.
interface vdiv16_seq_if #(
  parameter int NLANES = 16
);
  logic                 start;
  logic [15:0]          scalar;
  logic [16*NLANES-1:0] vecin;
  logic [16*NLANES-1:0] quotient;
  logic                 busy;
  logic                 done;
  logic                 Ovrflw;
  logic                 Undrflw;
  logic                 DivZero;
  logic                 Invalid;

  modport master (
    output start, scalar, vecin,
    input  quotient, busy, done, Ovrflw, Undrflw, DivZero, Invalid
  );

  modport slave (
    input  start, scalar, vecin,
    output quotient, busy, done, Ovrflw, Undrflw, DivZero, Invalid
  );
endinterface

// File: rtl/vdiv16_seq.sv
// Sequential vector-by-scalar binary16 divider: one restoring mantissa
// divider is shared across all lanes, 14 cycles per lane.
module vdiv16_seq #(
  parameter int NLANES = 16,
  parameter int QBITS  = 12
) (
  input logic         clk,
  input logic         rst_n,
  vdiv16_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LANE_PREP, DIV, PACK, DONE} state_t;
  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_DIV0, CLS_ZERO} cls_t;

  state_t               state, next_state;
  logic [15:0]          scl_q;
  logic [16*NLANES-1:0] vec_q;
  logic [16*NLANES-1:0] quot_q;
  logic [3:0]           lane;
  logic [3:0]           bit_cnt;
  logic [11:0]          rem;
  logic [QBITS-1:0]     qbits;
  logic                 sign;
  logic signed [7:0]    exp_diff;
  cls_t                 cls;
  logic                 busy_q, done_q;
  logic                 ovf_q, unf_q, dz_q, inv_q;

  logic [15:0]          lane_val;
  logic [4:0]           ea, eb;
  logic [10:0]          mb;
  logic [11:0]          diff;
  logic                 last_lane;
  logic                 accept;
  cls_t                 cls_next;
  logic signed [7:0]    e_res;
  logic [9:0]           frac;
  logic [15:0]          res;
  logic                 res_ovf, res_unf, res_dz, res_inv;

  assign lane_val  = vec_q[{lane, 4'b0000} +: 16];
  assign ea        = lane_val[14:10];
  assign eb        = scl_q[14:10];
  assign mb        = {1'b1, scl_q[9:0]};
  assign last_lane = (lane == 4'(NLANES - 1));
  assign accept    = (state == IDLE) && bus.start;

  // rem stays below 2*mb, so diff fits 12-bit two's complement and its
  // sign bit is the restoring compare result.
  assign diff = rem - {1'b0, mb};

  always_comb begin
    cls_next = CLS_NORM;
    if (ea == 5'h1f || eb == 5'h1f || (ea == 5'h00 && eb == 5'h00))
      cls_next = CLS_NAN;
    else if (eb == 5'h00)
      cls_next = CLS_DIV0;
    else if (ea == 5'h00)
      cls_next = CLS_ZERO;
  end

  always_comb begin
    e_res   = qbits[QBITS-1] ? exp_diff + 8'sd15 : exp_diff + 8'sd14;
    frac    = qbits[QBITS-1] ? qbits[10:1] : qbits[9:0];
    res     = {sign, e_res[4:0], frac};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_dz  = 1'b0;
    res_inv = 1'b0;
    unique case (cls)
      CLS_NAN: begin
        res     = 16'h7E00;
        res_inv = 1'b1;
      end
      CLS_DIV0: begin
        res    = {sign, 15'h7C00};
        res_dz = 1'b1;
      end
      CLS_ZERO: res = {sign, 15'h0000};
      default: begin
        if (e_res >= 8'sd31) begin
          res     = {sign, 15'h7C00};
          res_ovf = 1'b1;
        end else if (e_res <= 8'sd0) begin
          res     = {sign, 15'h0000};
          res_unf = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (bus.start) next_state = LANE_PREP;
      LANE_PREP: next_state = DIV;
      DIV:       if (bit_cnt == 4'(QBITS - 1)) next_state = PACK;
      PACK:      next_state = last_lane ? DONE : LANE_PREP;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q    <= '0;
      vec_q    <= '0;
      quot_q   <= '0;
      lane     <= '0;
      bit_cnt  <= '0;
      rem      <= '0;
      qbits    <= '0;
      sign     <= 1'b0;
      exp_diff <= '0;
      cls      <= CLS_NORM;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            scl_q  <= bus.scalar;
            vec_q  <= bus.vecin;
            quot_q <= '0;
            lane   <= '0;
            busy_q <= 1'b1;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            dz_q   <= 1'b0;
            inv_q  <= 1'b0;
          end
        end
        LANE_PREP: begin
          sign     <= lane_val[15] ^ scl_q[15];
          exp_diff <= $signed({3'b000, ea}) - $signed({3'b000, eb});
          rem      <= {2'b01, lane_val[9:0]};
          qbits    <= '0;
          bit_cnt  <= '0;
          cls      <= cls_next;
        end
        DIV: begin
          qbits   <= {qbits[QBITS-2:0], ~diff[11]};
          rem     <= diff[11] ? {rem[10:0], 1'b0} : {diff[10:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        PACK: begin
          quot_q[{lane, 4'b0000} +: 16] <= res;
          ovf_q <= ovf_q | res_ovf;
          unf_q <= unf_q | res_unf;
          dz_q  <= dz_q  | res_dz;
          inv_q <= inv_q | res_inv;
          if (!last_lane) lane <= lane + 4'd1;
        end
        DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.quotient = quot_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Ovrflw   = ovf_q;
  assign bus.Undrflw  = unf_q;
  assign bus.DivZero  = dz_q;
  assign bus.Invalid  = inv_q;

endmodule
